// File: rtl/mips_cpu_instr_memory_if.sv
// Load port carrying the program image into the instruction memory.
// Word-by-word valid/ready transfer with an end-of-image marker.
interface mips_cpu_instr_memory_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/mips_cpu_instr_memory.sv
// Instruction memory for mips_cpu_harvard: image loaded over a
// valid/ready port, then served combinationally to the CPU.
module mips_cpu_instr_memory #(
  parameter logic [31:0] BASE_ADDR = 32'hBFC00000,
  parameter int          DEPTH     = 64,
  parameter int          CNT_W     = 16,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  mips_cpu_instr_memory_if.slave load,
  output logic             cpu_reset,
  input  logic             cpu_active,
  input  logic [31:0]      instr_address,
  output logic [31:0]      instr_readdata,
  output logic             loaded,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] fetch_count,
  output logic [AW:0]      load_count
);

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DONE
  } state_t;

  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LAST = (AW + 1)'(DEPTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [AW:0]      ptr_q;
  logic [31:0]      mem [DEPTH];
  logic [DEPTH-1:0] vld_q;

  logic        fire;
  logic        running;
  logic        aligned;
  logic        in_range;
  logic        hit;
  logic [31:0] off;
  logic [AW-1:0] idx;

  assign load.load_ready = (state_q == LOAD) && (ptr_q < FULL);
  assign fire     = load.load_valid && load.load_ready;
  assign off      = instr_address - BASE_ADDR;
  assign aligned  = (instr_address[1:0] == 2'b00);
  assign in_range = (off < SPAN);
  assign idx      = off[AW+1:2];
  assign running  = (state_q == RUN) && !cpu_reset;
  assign hit      = (state_q == RUN) && aligned && in_range && vld_q[idx];

  assign instr_readdata = hit ? mem[idx] : 32'h0;
  assign loaded         = (state_q != LOAD);
  assign load_count     = ptr_q;

  // Next state: finish loading on last/full, stop on a fetch of 0.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: begin
        if (fire && (load.load_last || ptr_q == LAST))
          state_d = RUN;
        else if (ptr_q == FULL)
          state_d = RUN;
      end
      RUN: begin
        if (running && instr_address == 32'h0)
          state_d = DONE;
      end
      DONE: state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  // Control state, load pointer, valid bits and run-time status.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= LOAD;
      ptr_q       <= '0;
      vld_q       <= '0;
      cpu_reset   <= 1'b1;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      state_q   <= state_d;
      cpu_reset <= (state_q == LOAD);
      if (fire) begin
        ptr_q                <= ptr_q + 1'b1;
        vld_q[ptr_q[AW-1:0]] <= 1'b1;
      end
      if (running) begin
        if (cpu_active && fetch_count != '1)
          fetch_count <= fetch_count + 1'b1;
        if (instr_address == 32'h0)
          halted <= 1'b1;
        else if (!aligned || !in_range)
          fault <= 1'b1;
      end
    end
  end

  // Image storage; contents survive reset, validity does not.
  always_ff @(posedge clk) begin
    if (reset && fire)
      mem[ptr_q[AW-1:0]] <= load.load_data;
  end

endmodule
